// File: rtl/id_ex_issue.sv
// id_ex_issue: decode-and-issue stage between IF/ID and the EX-stage ALU.
// Decodes ir_id, forwards rs/rt from EX and MEM, selects the immediate form,
// detects load-use hazards and registers the ALU operands plus writeback and
// store metadata.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ir_id, valid_id                  instruction in IF/ID and its valid flag
//   rf_rdata1, rf_rdata2             register-file data for rs / rt
//   alu_out, over_flow               result and overflow of the EX instruction
//   mem_wen, mem_waddr, mem_wdata    pending write of the MEM instruction
//   hold, flush                      downstream stall / kill ID instruction
//   alu_a, alu_b, ir_ex              registered ALU operands and instruction
//   ex_wen, ex_waddr, ex_is_load     EX destination and load flag
//   ex_store_data                    forwarded rt value for SW
//   stall_id                         combinational IF/ID hold request
module id_ex_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir_id,
    input  logic        valid_id,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic [31:0] alu_out,
    input  logic        over_flow,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        hold,
    input  logic        flush,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ir_ex,
    output logic        ex_wen,
    output logic [4:0]  ex_waddr,
    output logic        ex_is_load,
    output logic [31:0] ex_store_data,
    output logic        stall_id
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // EX register
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [DW-1:0] ir_ex_q, ir_ex_d;
    logic          ex_wen_q, ex_wen_d;
    logic [RW-1:0] ex_waddr_q, ex_waddr_d;
    logic          ex_is_load_q, ex_is_load_d;
    logic [DW-1:0] ex_store_data_q, ex_store_data_d;

    // Decode results
    logic [5:0]    opcode, funct;
    logic [RW-1:0] rs, rt, rd, dest;
    logic          legal, use_rs, use_rt, a_zero, b_imm, imm_sext, is_load, is_store;
    logic [DW-1:0] imm_ext, rs_fwd, rt_fwd;
    logic          ex_fwd_ok, hazard, stall_c;

    // Forwarding priority: $0, then EX (not loads, not overflowed), then MEM, then RF
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] r,
        input logic [DW-1:0] rf,
        input logic          ex_ok,
        input logic [RW-1:0] ex_addr,
        input logic [DW-1:0] ex_data,
        input logic          m_wen,
        input logic [RW-1:0] m_addr,
        input logic [DW-1:0] m_data
    );
        logic [DW-1:0] v;
        if (r == '0) begin
            v = '0;
        end else if (ex_ok && (ex_addr == r)) begin
            v = ex_data;
        end else if (m_wen && (m_addr == r)) begin
            v = m_data;
        end else begin
            v = rf;
        end
        return v;
    endfunction

    // Instruction decode
    always_comb begin
        opcode   = ir_id[31:26];
        funct    = ir_id[5:0];
        rs       = ir_id[25:21];
        rt       = ir_id[20:16];
        rd       = ir_id[15:11];
        legal    = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        dest     = '0;
        a_zero   = 1'b0;
        b_imm    = 1'b0;
        imm_sext = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        legal  = 1'b1;
                        use_rt = 1'b1;
                        a_zero = 1'b1;
                        dest   = rd;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        legal  = 1'b1;
                        use_rs = 1'b1;
                        use_rt = 1'b1;
                        dest   = rd;
                    end
                    default: ;  // JR and unsupported functs issue as bubbles
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                legal    = 1'b1;
                use_rs   = 1'b1;
                dest     = rt;
                b_imm    = 1'b1;
                imm_sext = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                legal  = 1'b1;
                use_rs = 1'b1;
                dest   = rt;
                b_imm  = 1'b1;
            end
            OP_LUI: begin
                legal  = 1'b1;
                a_zero = 1'b1;
                dest   = rt;
                b_imm  = 1'b1;
            end
            OP_LW: begin
                legal    = 1'b1;
                use_rs   = 1'b1;
                dest     = rt;
                b_imm    = 1'b1;
                imm_sext = 1'b1;
                is_load  = 1'b1;
            end
            OP_SW: begin
                legal    = 1'b1;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                b_imm    = 1'b1;
                imm_sext = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
        imm_ext = imm_sext ? {{16{ir_id[15]}}, ir_id[15:0]} : {16'h0000, ir_id[15:0]};
    end

    // Operand forwarding and load-use detection
    always_comb begin
        ex_fwd_ok = ex_wen_q && !ex_is_load_q && !over_flow;
        rs_fwd = fwd_sel(rs, rf_rdata1, ex_fwd_ok, ex_waddr_q, alu_out,
                         mem_wen, mem_waddr, mem_wdata);
        rt_fwd = fwd_sel(rt, rf_rdata2, ex_fwd_ok, ex_waddr_q, alu_out,
                         mem_wen, mem_waddr, mem_wdata);
        hazard = valid_id && ex_is_load_q && ex_wen_q &&
                 ((use_rs && (rs != '0) && (rs == ex_waddr_q)) ||
                  (use_rt && (rt != '0) && (rt == ex_waddr_q)));
        stall_c = hold || (hazard && !flush);
    end

    // EX register next state: hold, else bubble, else issue
    always_comb begin
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        ir_ex_d         = ir_ex_q;
        ex_wen_d        = ex_wen_q;
        ex_waddr_d      = ex_waddr_q;
        ex_is_load_d    = ex_is_load_q;
        ex_store_data_d = ex_store_data_q;
        if (!hold) begin
            if (flush || hazard || !valid_id || !legal) begin
                alu_a_d         = '0;
                alu_b_d         = '0;
                ir_ex_d         = '0;
                ex_wen_d        = 1'b0;
                ex_waddr_d      = '0;
                ex_is_load_d    = 1'b0;
                ex_store_data_d = '0;
            end else begin
                alu_a_d         = a_zero ? '0 : rs_fwd;
                alu_b_d         = b_imm ? imm_ext : rt_fwd;
                ir_ex_d         = ir_id;
                ex_wen_d        = (dest != '0);
                ex_waddr_d      = dest;
                ex_is_load_d    = is_load;
                ex_store_data_d = is_store ? rt_fwd : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            ir_ex_q         <= '0;
            ex_wen_q        <= 1'b0;
            ex_waddr_q      <= '0;
            ex_is_load_q    <= 1'b0;
            ex_store_data_q <= '0;
        end else begin
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            ir_ex_q         <= ir_ex_d;
            ex_wen_q        <= ex_wen_d;
            ex_waddr_q      <= ex_waddr_d;
            ex_is_load_q    <= ex_is_load_d;
            ex_store_data_q <= ex_store_data_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign ir_ex         = ir_ex_q;
    assign ex_wen        = ex_wen_q;
    assign ex_waddr      = ex_waddr_q;
    assign ex_is_load    = ex_is_load_q;
    assign ex_store_data = ex_store_data_q;
    assign stall_id      = stall_c;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed scenarios plus randomized traffic for id_ex_issue,
// checked against a behavioural model of the EX register and stall request.
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir_id;
    logic        valid_id;
    logic [31:0] rf_rdata1, rf_rdata2, alu_out, mem_wdata;
    logic        over_flow, mem_wen, hold, flush;
    logic [4:0]  mem_waddr;
    logic [31:0] alu_a, alu_b, ir_ex, ex_store_data;
    logic        ex_wen, ex_is_load, stall_id;
    logic [4:0]  ex_waddr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_issue dut (
        .clk(clk), .rst_n(rst_n), .ir_id(ir_id), .valid_id(valid_id),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_out(alu_out), .over_flow(over_flow),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .hold(hold), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .ir_ex(ir_ex),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_is_load(ex_is_load),
        .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic        wen;
        logic [4:0]  waddr;
        logic        ld;
    } ex_t;

    typedef enum int {K_BAD, K_RRR, K_SHIFT, K_IMM_S, K_IMM_Z, K_LUI, K_LOAD, K_STORE} kind_e;

    ex_t m_ex;     // expected EX register contents
    ex_t m_nxt;
    bit  m_stall;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] ir);
        logic [5:0] op, fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03}) return K_SHIFT;
            if (fn inside {6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) return K_RRR;
            return K_BAD;
        end
        if (op inside {6'h08, 6'h0A}) return K_IMM_S;
        if (op inside {6'h0C, 6'h0D, 6'h0E}) return K_IMM_Z;
        if (op == 6'h0F) return K_LUI;
        if (op == 6'h23) return K_LOAD;
        if (op == 6'h2B) return K_STORE;
        return K_BAD;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'h0;
        if (m_ex.wen && m_ex.waddr == r && !m_ex.ld && !over_flow) return alu_out;
        if (mem_wen && mem_waddr == r) return mem_wdata;
        return rf;
    endfunction

    // Compute expected stall_id and next EX contents from current inputs
    task automatic model_eval();
        kind_e k;
        logic [4:0] rs, rt, rd, dst;
        bit rd_rs, rd_rt, hz;
        logic [31:0] sx, zx;
        k  = classify(ir_id);
        rs = ir_id[25:21];
        rt = ir_id[20:16];
        rd = ir_id[15:11];
        sx = {{16{ir_id[15]}}, ir_id[15:0]};
        zx = {16'h0, ir_id[15:0]};
        rd_rs = (k inside {K_RRR, K_IMM_S, K_IMM_Z, K_LOAD, K_STORE});
        rd_rt = (k inside {K_RRR, K_SHIFT, K_STORE});
        dst = (k inside {K_RRR, K_SHIFT}) ? rd :
              (k inside {K_IMM_S, K_IMM_Z, K_LUI, K_LOAD}) ? rt : 5'd0;
        hz = valid_id && m_ex.ld && m_ex.wen &&
             ((rd_rs && rs != 0 && rs == m_ex.waddr) || (rd_rt && rt != 0 && rt == m_ex.waddr));
        m_stall = hold || (hz && !flush);
        if (hold) m_nxt = m_ex;
        else if (flush || hz || !valid_id || k == K_BAD) m_nxt = '0;
        else begin
            m_nxt.ir    = ir_id;
            m_nxt.a     = (k inside {K_SHIFT, K_LUI}) ? 32'h0 : ref_fwd(rs, rf_rdata1);
            m_nxt.b     = (k inside {K_RRR, K_SHIFT}) ? ref_fwd(rt, rf_rdata2) :
                          (k inside {K_IMM_Z, K_LUI}) ? zx : sx;
            m_nxt.wen   = (dst != 0);
            m_nxt.waddr = dst;
            m_nxt.ld    = (k == K_LOAD);
            m_nxt.sd    = (k == K_STORE) ? ref_fwd(rt, rf_rdata2) : 32'h0;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".ir_ex"}, ir_ex, m_ex.ir);
        check({tag, ".alu_a"}, alu_a, m_ex.a);
        check({tag, ".alu_b"}, alu_b, m_ex.b);
        check({tag, ".ex_wen"}, 32'(ex_wen), 32'(m_ex.wen));
        check({tag, ".ex_waddr"}, 32'(ex_waddr), 32'(m_ex.waddr));
        check({tag, ".ex_is_load"}, 32'(ex_is_load), 32'(m_ex.ld));
        check({tag, ".store_data"}, ex_store_data, m_ex.sd);
    endtask

    // Inputs already driven; check stall, clock once, check EX register
    task automatic step(input string tag);
        #1;
        model_eval();
        check({tag, ".stall_id"}, 32'(stall_id), 32'(m_stall));
        @(posedge clk);
        #1;
        m_ex = m_nxt;
        check_outs(tag);
    endtask

    task automatic idle_inputs();
        ir_id = 32'h0; valid_id = 1'b1; rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
        alu_out = 32'h0; over_flow = 1'b0; mem_wen = 1'b0; mem_waddr = 5'd0;
        mem_wdata = 32'h0; hold = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [8];
        logic [5:0] fns [17];
        logic [4:0] rs, rt, rd;
        ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08};
        rs = 5'($urandom_range(7));
        rt = 5'($urandom_range(7));
        rd = 5'($urandom_range(7));
        case ($urandom_range(15))
            0:            return $urandom;
            1, 2, 3, 4, 5, 6, 7:
                return rtype(rs, rt, rd, 5'($urandom_range(31)), fns[$urandom_range(16)]);
            default:      return itype(ops[$urandom_range(7)], rs, rt, 16'($urandom));
        endcase
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        m_ex = '0;
        #12;
        check_outs("reset");
        check("reset.stall_id", 32'(stall_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // EX forwarding beats stale RF data
        ir_id = itype(6'h08, 5'd0, 5'd1, 16'd5);
        step("addi1");
        ir_id = rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20);
        alu_out = 32'd5;
        step("add_fwd");
        check("add_fwd.a5", alu_a, 32'd5);
        check("add_fwd.b5", alu_b, 32'd5);

        // Overflowing EX result is not forwarded; MEM hit still is
        idle_inputs();
        ir_id = itype(6'h08, 5'd0, 5'd3, 16'd1);
        step("addi3");
        ir_id = itype(6'h08, 5'd3, 5'd11, 16'd0);
        over_flow = 1'b1; alu_out = 32'h8000_0000; rf_rdata1 = 32'd7;
        step("ovf_rf");
        check("ovf_rf.a7", alu_a, 32'd7);
        ir_id = itype(6'h08, 5'd0, 5'd3, 16'd1);
        over_flow = 1'b0;
        step("addi3b");
        ir_id = itype(6'h08, 5'd3, 5'd11, 16'd0);
        over_flow = 1'b1; mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'd9;
        step("ovf_mem");
        check("ovf_mem.a9", alu_a, 32'd9);

        // Load-use: one bubble, then MEM supplies the load data
        idle_inputs();
        ir_id = itype(6'h23, 5'd0, 5'd4, 16'd0);
        step("lw");
        ir_id = rtype(5'd4, 5'd6, 5'd5, 5'd0, 6'h22);
        #1;
        check("lu.stall1", 32'(stall_id), 32'h1);
        step("lu_bubble");
        check("lu.bubble_ir", ir_ex, 32'h0);
        mem_wen = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h1234;
        #1;
        check("lu.stall0", 32'(stall_id), 32'h0);
        step("lu_issue");
        check("lu.a1234", alu_a, 32'h1234);

        // Immediate forms
        idle_inputs();
        ir_id = itype(6'h08, 5'd1, 5'd2, 16'hFFFF);
        step("addi_sx");
        check("addi_sx.b", alu_b, 32'hFFFF_FFFF);
        ir_id = itype(6'h0D, 5'd1, 5'd2, 16'hFFFF);
        step("ori_zx");
        check("ori_zx.b", alu_b, 32'h0000_FFFF);
        ir_id = rtype(5'd0, 5'd8, 5'd7, 5'd3, 6'h00);
        rf_rdata2 = 32'hCAFE_0008;
        step("sll");
        check("sll.a", alu_a, 32'h0);
        check("sll.b", alu_b, 32'hCAFE_0008);
        ir_id = itype(6'h2B, 5'd10, 5'd9, 16'd4);
        rf_rdata2 = 32'h0000_0909;
        step("sw");
        check("sw.wen", 32'(ex_wen), 32'h0);
        check("sw.sd", ex_store_data, 32'h0000_0909);

        // Hold freezes for three cycles, then flush / illegal / $0 writes
        ir_id = itype(6'h08, 5'd1, 5'd5, 16'd3);
        hold = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            check("hold.stall", 32'(stall_id), 32'h1);
        end
        hold = 1'b0;
        step("flush");
        check("flush.ir", ir_ex, 32'h0);
        flush = 1'b0;
        ir_id = rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h08);
        step("jr");
        ir_id = 32'hFC00_0000;
        step("op3f");
        ir_id = itype(6'h08, 5'd1, 5'd0, 16'd3);
        step("wr_r0");
        check("wr_r0.wen", 32'(ex_wen), 32'h0);
        ir_id = itype(6'h23, 5'd0, 5'd6, 16'd8);
        step("lw6");

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        m_ex = '0;
        check_outs("async_rst");
        #2;
        rst_n = 1'b1;
        idle_inputs();
        ir_id = itype(6'h0E, 5'd2, 5'd3, 16'h00F0);
        step("post_rst");
        check("post_rst.ir", ir_ex, itype(6'h0E, 5'd2, 5'd3, 16'h00F0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ir_id     = rand_instr();
            valid_id  = ($urandom_range(9) != 0);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            alu_out   = $urandom;
            over_flow = ($urandom_range(5) == 0);
            mem_wen   = $urandom_range(1) == 1;
            mem_waddr = 5'($urandom_range(7));
            mem_wdata = $urandom;
            hold      = ($urandom_range(9) == 0);
            flush     = ($urandom_range(9) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-and-issue stage of the five-stage MIPS pipeline, sitting between the IF/ID register and the EX-stage ALU. Each cycle it decodes the ID instruction, resolves operands with forwarding from EX and MEM, and selects the immediate form. It registers `alu_a`, `alu_b` and `ir_ex` (the values the ALU consumes) plus writeback and store metadata. It also detects load-use hazards, inserting one bubble and stalling IF/ID.

## Interface
- No parameters. Data width is fixed at 32 bits and the register index at 5 bits.
- `clk` in 1: the single clock. All registers update on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ir_id` in 32: instruction held in IF/ID.
- `valid_id` in 1: `ir_id` is a real instruction. When 0, the stage issues a bubble.
- `rf_rdata1`, `rf_rdata2` in 32: register-file read data for rs (`ir_id[25:21]`) and rt (`ir_id[20:16]`). The register file is write-through.
- `alu_out` in 32, `over_flow` in 1: combinational result and overflow of the instruction currently in EX.
- `mem_wen` in 1, `mem_waddr` in 5, `mem_wdata` in 32: pending write of the instruction in MEM. This is final data, including load data.
- `hold` in 1: downstream stall. When 1, the EX register freezes.
- `flush` in 1: kills the ID instruction, so EX loads a bubble.
- `alu_a`, `alu_b` out 32: registered ALU operands.
- `ir_ex` out 32: registered instruction. This is 0 (NOP) for a bubble.
- `ex_wen` out 1, `ex_waddr` out 5: destination of the EX instruction.
- `ex_is_load` out 1: the EX instruction is LW.
- `ex_store_data` out 32: forwarded rt value for SW.
- `stall_id` out 1: combinational. IF/ID must hold.

## Operation
- **Decode.** Opcode is `ir[31:26]`; funct is `ir[5:0]` when the opcode is 0.
- **Register reads:**
  - R-type arithmetic/logic, SLT, SLTU, SLLV, SRLV, SRAV: reads rs and rt.
  - SLL, SRL, SRA: read rt only.
  - ADDI, ANDI, XORI, SLTI, ORI, LW: read rs.
  - SW: reads rs and rt.
  - LUI: reads nothing.
- **Destination:**
  - R-type: rd (`ir[15:11]`).
  - ADDI, ANDI, XORI, SLTI, ORI, LUI, LW: rt.
  - SW: none.
  - `ex_wen` is 0 whenever the destination is $0.
- **Operand A:** `alu_a` is the forwarded rs value. For SLL, SRL, SRA and LUI it is 0.
- **Operand B:**
  - R-type: forwarded rt.
  - ADDI, SLTI, LW, SW: sign-extended `ir[15:0]`.
  - ANDI, ORI, XORI, LUI: zero-extended `ir[15:0]`.
- **Bubbles for non-issuable instructions:** JR (opcode 0, funct 001000) and any opcode or funct outside the supported set issue as a bubble. JR is resolved in front of this stage.
- **Forwarding:** applied per source register r, with priority from highest to lowest:
  1. r == 0 gives 0.
  2. The EX hit (`ex_wen` && `ex_waddr` == r && !`ex_is_load` && !`over_flow`) gives `alu_out`.
  3. The MEM hit (`mem_wen` && `mem_waddr` == r) gives `mem_wdata`.
  4. Otherwise, the register-file data.
  - An overflowing EX instruction is never forwarded, because its write is discarded downstream.
- **Load-use hazard:** `ex_is_load` && `ex_wen` && `ex_waddr` equals a register the ID instruction reads (nonzero) && `valid_id`.
- **Register update priority:**
  1. `hold` = 1: all EX outputs keep their values.
  2. `flush` = 1: load a bubble.
  3. Load-use hazard: load a bubble.
  4. `valid_id` = 0: load a bubble.
  5. Otherwise: load the decoded instruction.
- **Bubble contents:** `ir_ex` = 0, `alu_a` = 0, `alu_b` = 0, `ex_wen` = 0, `ex_waddr` = 0, `ex_is_load` = 0, `ex_store_data` = 0.
- **`stall_id`:** equals `hold` | (hazard & !`flush`).
- **Reset:** every output register is 0, which is a bubble. `stall_id` then follows its combinational equation.

## Timing
- Issue latency is 1 cycle: the ID instruction appears on `ir_ex`/`alu_a`/`alu_b` after the next rising edge.
- A load-use hazard costs exactly one bubble. In the following cycle the load is in MEM, and `mem_wdata` supplies the value.
- `stall_id` is valid in the same cycle as the hazard. IF/ID samples it at the same edge.
- `flush` and `hold` asserted together: `hold` wins. The EX register freezes and `flush` is ignored; the pipeline controller never does this intentionally.
- Reset asserted mid-operation clears EX immediately, independent of `clk`. Issue resumes on the first edge after `rst_n` rises.

## Test plan
- **Forwarding from EX:** `addi $1,$0,5` then `add $2,$1,$1`, with `alu_out` = 5 in EX. Required: the second instruction's `alu_a` = `alu_b` = 5, ignoring stale `rf_rdata`.
- **Overflow blocks forwarding:** EX writes $3 with `over_flow` = 1, `alu_out` = 0x80000000, and `rf_rdata1` = 7. Required: `alu_a` = 7. The MEM hit for $3 with `mem_wdata` = 9 gives `alu_a` = 9.
- **Load-use:** `lw $4,0($0)` then `sub $5,$4,$6`. Required: `stall_id` = 1 for one cycle and a bubble (`ir_ex` = 0) issued. Next cycle: `mem_waddr` = 4, `mem_wdata` = 0x1234, so `alu_a` = 0x1234 and `stall_id` = 0.
- **Immediates:** `addi` imm 0xFFFF gives `alu_b` = 0xFFFFFFFF. `ori` imm 0xFFFF gives 0x0000FFFF. `sll $7,$8,3` gives `alu_a` = 0 and `alu_b` = forwarded $8. `sw $9,4($10)` gives `ex_wen` = 0 and `ex_store_data` = $9.
- **Control priority:**
  - `hold` = 1 for 3 cycles: outputs frozen, `stall_id` = 1.
  - `flush` = 1 with `hold` = 0: bubble issued.
  - JR or opcode 0x3F: bubble issued.
  - Writes to $0 give `ex_wen` = 0.
- **Reset:** assert `rst_n` = 0 mid-stream between clock edges. Required: all outputs are 0 immediately. After release, the first valid instruction issues one edge later.
